// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: per-FU round-robin pick of station heads, FU occupancy tracking, writeback tag broadcast.
// Latency: grant/req_ready combinational in the request cycle; wb_valid/wb_tag FU_LATENCY cycles after the grant.
// Backpressure: a busy FU (cnt > 1) or a flush grants nothing; ungranted requests simply see req_ready=0 and hold.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_fu_sel/req_dest_tag  station head valid, target FU, destination tag (per requester)
//   req_ready                    pop handshake back to the winning station
//   fu_issue_valid/fu_issue_src  issue strobe and winning requester index (per FU)
//   wb_valid/wb_tag              completion strobe and destination tag (per FU), feeds station wakeup
//   fu_busy                      FU cannot accept an op this cycle
//   flush                        kills in-flight ops, suppresses grants and writebacks
//   conflict_cnt                 per-FU saturating count of cycles with a denied request
//                                (present only when ISSUE_CONFLICT_STATS_EN is defined)
module rs_issue_scheduler #(
    parameter int REQUESTERS = 4,
    parameter int FUNITS     = 2,
    parameter int FU_LATENCY = 3,
    parameter int REGISTERS  = 128,
    localparam int TW    = $clog2(REGISTERS),
    localparam int SEL_W = (FUNITS > 1) ? $clog2(FUNITS) : 1,
    localparam int SRC_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [REQUESTERS-1:0]               req_valid,
    input  logic [REQUESTERS-1:0][SEL_W-1:0]    req_fu_sel,
    input  logic [REQUESTERS-1:0][TW-1:0]       req_dest_tag,
    output logic [REQUESTERS-1:0]               req_ready,
    output logic [FUNITS-1:0]                   fu_issue_valid,
    output logic [FUNITS-1:0][SRC_W-1:0]        fu_issue_src,
    output logic [FUNITS-1:0]                   wb_valid,
    output logic [FUNITS-1:0][TW-1:0]           wb_tag,
    output logic [FUNITS-1:0]                   fu_busy,
    input  logic                                flush
`ifdef ISSUE_CONFLICT_STATS_EN
    ,
    output logic [FUNITS-1:0][15:0]             conflict_cnt
`endif
);

    localparam int CNT_W = $clog2(FU_LATENCY + 1);

    logic [FUNITS-1:0][SRC_W-1:0] rr_ptr;
    logic [FUNITS-1:0][CNT_W-1:0] cnt;
    logic [FUNITS-1:0][TW-1:0]    tag_q;

    logic [FUNITS-1:0][REQUESTERS-1:0] elig;

    // cnt==1 is the completion cycle; the FU is free again in that same
    // cycle, which is what gives back-to-back issue every FU_LATENCY cycles.
    always_comb begin
        fu_busy  = '0;
        wb_valid = '0;
        wb_tag   = tag_q;
        for (int f = 0; f < FUNITS; f++) begin
            fu_busy[f]  = (cnt[f] > CNT_W'(1));
            wb_valid[f] = (cnt[f] == CNT_W'(1)) && !flush;
        end
    end

    // A select value at or above FUNITS never equals any f, so such
    // requests are never eligible anywhere.
    always_comb begin
        elig = '0;
        for (int f = 0; f < FUNITS; f++) begin
            for (int r = 0; r < REQUESTERS; r++) begin
                elig[f][r] = req_valid[r] && (req_fu_sel[r] == SEL_W'(f))
                             && !fu_busy[f] && !flush;
            end
        end
    end

    // Independent round-robin per FU starting at rr_ptr. Each request names
    // exactly one FU, so a requester can win at most one arbiter.
    always_comb begin : arb
        int   idx;
        logic found;
        idx            = 0;
        found          = 1'b0;
        req_ready      = '0;
        fu_issue_valid = '0;
        fu_issue_src   = '0;
        for (int f = 0; f < FUNITS; f++) begin
            found = 1'b0;
            for (int i = 0; i < REQUESTERS; i++) begin
                idx = (int'(rr_ptr[f]) + i) % REQUESTERS;
                if (!found && elig[f][idx]) begin
                    found             = 1'b1;
                    fu_issue_valid[f] = 1'b1;
                    fu_issue_src[f]   = SRC_W'(idx);
                    req_ready[idx]    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            cnt    <= '0;
            tag_q  <= '0;
        end else begin
            for (int f = 0; f < FUNITS; f++) begin
                if (fu_issue_valid[f]) begin
                    // A grant in the completion cycle replaces the finished op.
                    rr_ptr[f] <= SRC_W'((int'(fu_issue_src[f]) + 1) % REQUESTERS);
                    cnt[f]    <= CNT_W'(FU_LATENCY);
                    tag_q[f]  <= req_dest_tag[fu_issue_src[f]];
                end else if (flush) begin
                    cnt[f] <= '0;
                end else if (cnt[f] != '0) begin
                    cnt[f] <= cnt[f] - 1'b1;
                end
            end
        end
    end

`ifdef ISSUE_CONFLICT_STATS_EN
    logic [FUNITS-1:0] conflict;

    always_comb begin
        conflict = '0;
        for (int f = 0; f < FUNITS; f++) begin
            for (int r = 0; r < REQUESTERS; r++) begin
                if (req_valid[r] && (req_fu_sel[r] == SEL_W'(f)) && !req_ready[r]) begin
                    conflict[f] = 1'b1;
                end
            end
        end
    end

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else begin
            for (int f = 0; f < FUNITS; f++) begin
                if (conflict[f] && (conflict_cnt[f] != 16'hFFFF)) begin
                    conflict_cnt[f] <= conflict_cnt[f] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
